// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame-format encodings and data-length limits.
// Used by both the configurable transmitter and its receiver counterpart.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
   typedef enum logic [1:0] {STOP_1, STOP_1P5, STOP_2} stop_e;

   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned MAX_DATA_BITS = 9;

   // Code 11 is not a legal parity setting and is sent as no parity.
   function automatic parity_e decode_parity(input logic [1:0] code);
      case (code)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

   // Code 11 is not a legal stop setting and is sent as two stop bits.
   function automatic stop_e decode_stop(input logic [1:0] code);
      case (code)
         2'b00:   return STOP_1;
         2'b01:   return STOP_1P5;
         default: return STOP_2;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..DATA_BITS data bits, none/even/odd parity,
// 1/1.5/2 stop bits), paced by an oversampling tick, with registered outputs.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned OVS       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tic,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] din,
   input  logic [3:0]           cfg_nbits,
   input  logic [1:0]           cfg_parity,
   input  logic [1:0]           cfg_stop,
   output logic                 tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned CW = $clog2(2 * OVS);
   localparam logic [CW-1:0] BIT_LAST = CW'(OVS - 1);

   tx_state_e            state;
   logic [CW-1:0]        tick_cnt;
   logic [3:0]           bit_cnt;
   logic [3:0]           nbits;
   logic [DATA_BITS-1:0] shift_reg;
   parity_e              parity;
   stop_e                stop_len;
   logic                 par_bit;

   logic [3:0]           nbits_clamped;
   logic [DATA_BITS-1:0] din_masked;
   logic [CW-1:0]        tick_last;
   logic                 bit_end;
   parity_e              parity_req;

   always_comb begin
      if (cfg_nbits < 4'(MIN_DATA_BITS))
         nbits_clamped = 4'(MIN_DATA_BITS);
      else if (cfg_nbits > 4'(DATA_BITS))
         nbits_clamped = 4'(DATA_BITS);
      else
         nbits_clamped = cfg_nbits;

      din_masked = '0;
      for (int unsigned i = 0; i < DATA_BITS; i++)
         if (i < 32'(nbits_clamped))
            din_masked[i] = din[i];

      parity_req = decode_parity(cfg_parity);
   end

   // Only the stop bit has a configurable length; every other bit is OVS tics.
   always_comb begin
      tick_last = BIT_LAST;
      if (state == STOP) begin
         case (stop_len)
            STOP_1:   tick_last = CW'(OVS - 1);
            STOP_1P5: tick_last = CW'((3 * OVS) / 2 - 1);
            default:  tick_last = CW'(2 * OVS - 1);
         endcase
      end
      bit_end = tic && (tick_cnt == tick_last);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         nbits     <= '0;
         shift_reg <= '0;
         parity    <= PAR_NONE;
         stop_len  <= STOP_1;
         par_bit   <= 1'b0;
         tx_data   <= 1'b1;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state != IDLE && tic)
            tick_cnt <= bit_end ? '0 : tick_cnt + CW'(1);

         case (state)
            IDLE: begin
               if (tx_start) begin
                  shift_reg <= din;
                  nbits     <= nbits_clamped;
                  parity    <= parity_req;
                  stop_len  <= decode_stop(cfg_stop);
                  par_bit   <= (^din_masked) ^ (parity_req == PAR_ODD);
                  tick_cnt  <= '0;
                  bit_cnt   <= '0;
                  state     <= START;
                  tx_data   <= 1'b0;
                  tx_busy   <= 1'b1;
                  tx_ready  <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  tx_data <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= bit_cnt + 4'd1;
                  if (bit_cnt == nbits - 4'd1) begin
                     if (parity != PAR_NONE) begin
                        state   <= PARITY;
                        tx_data <= par_bit;
                     end else begin
                        state   <= STOP;
                        tx_data <= 1'b1;
                     end
                  end else begin
                     // shift_reg[1] becomes shift_reg[0] on this same edge.
                     tx_data <= shift_reg[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state   <= STOP;
                  tx_data <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state    <= IDLE;
                  tx_done  <= 1'b1;
                  tx_busy  <= 1'b0;
                  tx_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame shapes per format, clamping, back-to-back
// frames, ignored mid-frame requests and reset abort.
module tb_uart_tx_cfg;

   localparam int unsigned DB  = 9;
   localparam int unsigned OVS = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          tic;
   logic          tx_start;
   logic [DB-1:0] din;
   logic [3:0]    cfg_nbits;
   logic [1:0]    cfg_parity;
   logic [1:0]    cfg_stop;
   logic          tx_data;
   logic          tx_ready;
   logic          tx_busy;
   logic          tx_done;

   int checks   = 0;
   int failures = 0;

   uart_tx_cfg #(.DATA_BITS(DB), .OVS(OVS)) dut (
      .clk        (clk),
      .reset      (reset),
      .tic        (tic),
      .tx_start   (tx_start),
      .din        (din),
      .cfg_nbits  (cfg_nbits),
      .cfg_parity (cfg_parity),
      .cfg_stop   (cfg_stop),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // One tic every 4 clocks, changed on the falling edge.
   initial begin : ticgen
      int unsigned div;
      div = 0;
      tic = 1'b0;
      forever begin
         @(negedge clk);
         tic = (div == 3);
         div = (div + 1) % 4;
      end
   end

   // Follows a frame that was accepted on the previous rising edge. vec holds the
   // line value per bit period (start, data, parity) in time order; stop follows.
   task automatic check_frame(input string name, input logic [11:0] vec,
                              input int unsigned nb, input int unsigned stop_tics,
                              input bit disturb);
      int unsigned total, k, cyc, bad, first_bad;
      logic exp_v, got_first, exp_first;
      bit early, busy_bad;
      total = nb * OVS + stop_tics;
      k = 0; cyc = 0; bad = 0; first_bad = 0;
      got_first = 1'b0; exp_first = 1'b0; early = 0; busy_bad = 0;
      while (k < total && cyc < total * 4 + 50) begin
         @(negedge clk); #1;
         cyc++;
         if (tx_done) early = 1;
         if (!tx_busy || tx_ready) busy_bad = 1;
         if (tic) begin
            exp_v = (k < nb * OVS) ? vec[k / OVS] : 1'b1;
            if (tx_data !== exp_v) begin
               if (bad == 0) begin
                  first_bad = k; got_first = tx_data; exp_first = exp_v;
               end
               bad++;
            end
            if (disturb && k == 40) begin
               tx_start = 1'b1; din = '0; cfg_nbits = 4'd5;
               cfg_parity = 2'b01; cfg_stop = 2'b00;
            end
            if (disturb && k == 60) tx_start = 1'b0;
            k++;
         end
      end
      checks++;
      if (k != total) begin
         failures++;
         $display("FAIL %s_length: saw %0d tics, required %0d", name, k, total);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s_line: tic %0d tx_data=%b required %b (%0d bad tics)",
                  name, first_bad, got_first, exp_first, bad);
      end
      checks++;
      if (early) begin
         failures++;
         $display("FAIL %s_early_done: tx_done=1 during frame, required 0", name);
      end
      checks++;
      if (busy_bad) begin
         failures++;
         $display("FAIL %s_busy: busy/ready dropped mid-frame, required busy=1 ready=0", name);
      end
      @(negedge clk); #1;
      checks++;
      if ({tx_done, tx_ready, tx_busy, tx_data} !== 4'b1101) begin
         failures++;
         $display("FAIL %s_end: done,ready,busy,data=%b required 1101", name,
                  {tx_done, tx_ready, tx_busy, tx_data});
      end
   endtask

   task automatic do_frame(input string name, input logic [DB-1:0] d, input logic [3:0] nbits,
                           input logic [1:0] par, input logic [1:0] stp,
                           input logic [11:0] vec, input int unsigned nb,
                           input int unsigned stop_tics, input bit disturb);
      @(negedge clk);
      din = d; cfg_nbits = nbits; cfg_parity = par; cfg_stop = stp; tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      check_frame(name, vec, nb, stop_tics, disturb);
      @(negedge clk); #1;
      checks++;
      if ({tx_done, tx_ready, tx_busy, tx_data} !== 4'b0101) begin
         failures++;
         $display("FAIL %s_after: done,ready,busy,data=%b required 0101", name,
                  {tx_done, tx_ready, tx_busy, tx_data});
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; tx_start = 1'b0; din = '0;
      cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({tx_data, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_state: data,ready,busy,done=%b required 1100",
                  {tx_data, tx_ready, tx_busy, tx_done});
      end
   endtask

   task automatic test_8n1;
      do_frame("8n1", 9'h0A5, 4'd8, 2'b00, 2'b00, {3'b000, 8'hA5, 1'b0}, 9, 16, 0);
   endtask

   task automatic test_parity;
      do_frame("7e1", 9'h055, 4'd7, 2'b01, 2'b00, {3'b000, 1'b0, 7'h55, 1'b0}, 9, 16, 0);
      // Bits above nbits are set and must not affect the parity bit.
      do_frame("7o2", 9'h1D5, 4'd7, 2'b10, 2'b10, {3'b000, 1'b1, 7'h55, 1'b0}, 9, 32, 0);
   endtask

   task automatic test_clamp;
      do_frame("5n1p5", 9'h1FF, 4'd3, 2'b00, 2'b01, {6'b000000, 5'h1F, 1'b0}, 6, 24, 0);
      do_frame("9o2", 9'h1A3, 4'd15, 2'b10, 2'b11, {1'b0, 1'b0, 9'h1A3, 1'b0}, 11, 32, 0);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      din = 9'h000; cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00; tx_start = 1'b1;
      @(posedge clk); #1;
      din = 9'h0FF; cfg_parity = 2'b11; cfg_stop = 2'b11;
      check_frame("b2b_first", {3'b000, 8'h00, 1'b0}, 9, 16, 0);
      @(posedge clk); #1;
      tx_start = 1'b0;
      checks++;
      if ({tx_data, tx_busy, tx_ready} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_restart: data,busy,ready=%b required 010",
                  {tx_data, tx_busy, tx_ready});
      end
      check_frame("b2b_second", {3'b000, 8'hFF, 1'b0}, 9, 32, 0);
      @(negedge clk); #1;
      checks++;
      if ({tx_done, tx_ready, tx_busy, tx_data} !== 4'b0101) begin
         failures++;
         $display("FAIL b2b_after: done,ready,busy,data=%b required 0101",
                  {tx_done, tx_ready, tx_busy, tx_data});
      end
   endtask

   task automatic test_mid_frame_ignore;
      do_frame("ignore", 9'h03C, 4'd8, 2'b00, 2'b00, {3'b000, 8'h3C, 1'b0}, 9, 16, 1);
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if ({tx_ready, tx_busy, tx_data} !== 3'b101) begin
         failures++;
         $display("FAIL ignore_no_second: ready,busy,data=%b required 101",
                  {tx_ready, tx_busy, tx_data});
      end
   endtask

   task automatic test_reset_mid_frame;
      int unsigned k, cyc;
      bit done_seen, line_low;
      @(negedge clk);
      din = 9'h0A5; cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00; tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      k = 0; cyc = 0;
      while (k < 72 && cyc < 1000) begin
         @(negedge clk); #1;
         cyc++;
         if (tic) k++;
      end
      checks++;
      if (k != 72 || tx_data !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_bit3: tics=%0d tx_data=%b required 72 and 0", k, tx_data);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({tx_data, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
         failures++;
         $display("FAIL rst_mid_state: data,ready,busy,done=%b required 1100",
                  {tx_data, tx_ready, tx_busy, tx_done});
      end
      done_seen = 0; line_low = 0;
      repeat (200) begin
         @(negedge clk); #1;
         if (tx_done) done_seen = 1;
         if (!tx_data) line_low = 1;
      end
      checks++;
      if (done_seen || line_low) begin
         failures++;
         $display("FAIL rst_mid_quiet: done_seen=%0d line_low=%0d required 0 0",
                  done_seen, line_low);
      end
      do_frame("rst_follow", 9'h04B, 4'd7, 2'b10, 2'b00, {3'b000, 1'b1, 7'h4B, 1'b0}, 9, 16, 0);
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_clamp();
      test_back_to_back();
      test_mid_frame_ignore();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
